// File: rtl/syn_md_trig_seq.sv
// syn_md_trig_seq: turns each accepted sync-modulation edge into a delayed
// burst of trigger pulses with programmable width, period and count. It also
// flags sync edges that arrive mid-sequence and counts accepted edges.
module syn_md_trig_seq #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             syn_md_out_en,
    input  logic             arm,
    input  logic [CNT_W-1:0] delay_cnt,
    input  logic [CNT_W-1:0] width_cnt,
    input  logic [CNT_W-1:0] period_cnt,
    input  logic [NUM_W-1:0] burst_num,
    output logic             trig_out,
    output logic             busy,
    output logic             done,
    output logic             ovr_err,
    output logic [CNT_W-1:0] edge_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_W-1:0]   r_pulse;
    logic [CNT_W-1:0]   r_width;
    logic [CNT_W-1:0]   r_low;
    logic [NUM_W-1:0]   r_burst;
    logic               r_trig;
    logic               r_busy;
    logic               r_done;
    logic               r_ovr;
    logic [CNT_W-1:0]   r_edgeCnt;

    state_t             w_stateNext;
    logic [CNT_W-1:0]   w_cntNext;
    logic [NUM_W-1:0]   w_pulseNext;
    logic               w_accept;
    logic               w_overrun;
    logic [CNT_W-1:0]   w_inWidth;
    logic [CNT_W-1:0]   w_inLow;
    logic [NUM_W-1:0]   w_inBurst;

    // Effective high time, low gap and pulse count derived from the live
    // inputs; these are what get captured into the shadow registers.
    assign w_inWidth = (width_cnt == '0) ? CNT_W'(1) : width_cnt;
    assign w_inLow   = (period_cnt > w_inWidth) ? (period_cnt - w_inWidth) : CNT_W'(1);
    assign w_inBurst = (burst_num == '0) ? NUM_W'(1) : burst_num;

    // Next-state, working-counter and pulse-counter logic; the working
    // counter holds the remaining cycles of the current state minus one.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_pulseNext = r_pulse;
        w_accept    = 1'b0;
        w_overrun   = 1'b0;
        if (!arm) begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
            w_pulseNext = '0;
        end else begin
            w_overrun = syn_md_out_en && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (syn_md_out_en) begin
                        w_accept = 1'b1;
                        if (delay_cnt != '0) begin
                            w_stateNext = DELAY;
                            w_cntNext   = delay_cnt - CNT_W'(1);
                        end else begin
                            w_stateNext = HIGH;
                            w_cntNext   = w_inWidth - CNT_W'(1);
                            w_pulseNext = NUM_W'(1);
                        end
                    end
                end
                DELAY: begin
                    if (r_cnt == '0) begin
                        w_stateNext = HIGH;
                        w_cntNext   = r_width - CNT_W'(1);
                        w_pulseNext = NUM_W'(1);
                    end else begin
                        w_cntNext = r_cnt - CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (r_cnt == '0) begin
                        if (r_pulse == r_burst) begin
                            w_stateNext = DONE;
                            w_cntNext   = '0;
                        end else begin
                            w_stateNext = LOW;
                            w_cntNext   = r_low - CNT_W'(1);
                        end
                    end else begin
                        w_cntNext = r_cnt - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (r_cnt == '0) begin
                        w_stateNext = HIGH;
                        w_cntNext   = r_width - CNT_W'(1);
                        w_pulseNext = r_pulse + NUM_W'(1);
                    end else begin
                        w_cntNext = r_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                    w_pulseNext = '0;
                end
                default: begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                    w_pulseNext = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs; outputs are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pulse   <= '0;
            r_trig    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_pulse   <= w_pulseNext;
            r_trig    <= (w_stateNext == HIGH);
            r_busy    <= (w_stateNext != IDLE);
            r_done    <= (w_stateNext == DONE);
        end
    end

    // Shadow copies of the burst fields, captured only when an edge is
    // accepted so the running burst ignores later input changes.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_width <= '0;
            r_low   <= '0;
            r_burst <= '0;
        end else if (w_accept) begin
            r_width <= w_inWidth;
            r_low   <= w_inLow;
            r_burst <= w_inBurst;
        end
    end

    // Accepted-edge counter and sticky overrun flag; disarming clears the
    // flag but leaves the counter untouched.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_edgeCnt <= '0;
            r_ovr     <= 1'b0;
        end else if (!arm) begin
            r_ovr     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_edgeCnt <= r_edgeCnt + CNT_W'(1);
            end
            if (w_overrun) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign trig_out = r_trig;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ovr_err  = r_ovr;
    assign edge_cnt = r_edgeCnt;

endmodule

// File: doc/syn_md_trig_seq.md
# syn_md_trig_seq

Downstream consumer of the sync-modulation rising-edge pulse `syn_md_out_en`. Each accepted edge starts a programmable delay, then a burst of trigger pulses with programmable width, period and count, which drives the acquisition/excitation sequencer. The block also flags sync edges that arrive while a burst is in progress and counts accepted edges for firmware readback.

## Interface
Parameters:
- CNT_W, 16, width of the delay, width and period counters and of `edge_cnt`
- NUM_W, 8, width of the burst-count field

Ports:
- clkin  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- syn_md_out_en  in  1  single-cycle sync edge pulse, synchronous to clkin
- arm  in  1  level enable; 0 aborts any sequence and clears `ovr_err`
- delay_cnt  in  CNT_W  edge-to-first-trigger delay in cycles
- width_cnt  in  CNT_W  trigger high time in cycles; 0 is treated as 1
- period_cnt  in  CNT_W  trigger period in cycles, rising edge to rising edge
- burst_num  in  NUM_W  pulses per edge; 0 is treated as 1
- trig_out  out  1  registered trigger output
- busy  out  1  high while a sequence is running
- done  out  1  one-cycle pulse after the last trigger completes
- ovr_err  out  1  sticky flag: an edge arrived while not IDLE
- edge_cnt  out  CNT_W  count of accepted edges; wraps

## Operation
- States: IDLE, DELAY, HIGH, LOW, DONE.
- **Accept.** In IDLE with arm=1 and syn_md_out_en=1:
  - latch delay_cnt, width_cnt, period_cnt and burst_num into shadow registers; later input changes do not affect the running burst;
  - increment edge_cnt (mod 2^CNT_W);
  - go to DELAY if the latched delay is nonzero, else go to HIGH.
- **DELAY.** Stays exactly D = latched delay cycles, then goes to HIGH.
- **HIGH.** Stays W = max(width, 1) cycles.
  - If this was the last pulse of the burst, go to DONE.
  - Otherwise go to LOW.
- **LOW.** Stays L = max(period − W, 1) cycles, then goes to HIGH.
  - When period ≤ W, the low gap is 1 cycle.
- **DONE.** Lasts 1 cycle, then goes to IDLE.
- **Pulse counter.** Counts HIGH entries against N = max(burst_num, 1).
- **Overrun.**
  - syn_md_out_en=1 while in DELAY, HIGH, LOW or DONE is ignored (no restart, edge_cnt unchanged) and sets ovr_err.
  - ovr_err stays set until arm=0.
- **Abort.** arm=0 in any state:
  - next cycle: state IDLE, trig_out=0, busy=0, done not asserted;
  - ovr_err=0 and edge_cnt is held.
- **Disarmed edges.** syn_md_out_en with arm=0 does nothing: not counted, no error.
- **Reset values.** trig_out=0, busy=0, done=0, ovr_err=0, edge_cnt=0, state IDLE, all shadow and working counters 0.
- **Reset mid-burst.** Outputs take their reset values immediately (asynchronously); the block resumes in IDLE after reset release.
- **trig_out implementation.** Must be a dedicated flop, set on entry to HIGH and cleared on exit. It must not be a combinational decode of the state.

## Timing
- Edge sampled at cycle T; busy=1 from T+1 through the DONE cycle inclusive.
- First trig_out rise: cycle T+1+D.
  - D=0 gives a rise at T+1, so latency from the edge pulse is 1 cycle.
- Pulse k (0-based) rises at T+1+D+k·(W+L).
  - W+L equals period_cnt when period_cnt > W.
- done is high for exactly the one cycle after the last HIGH cycle; busy falls with done.
- An edge in the cycle after DONE (state IDLE) is accepted normally. Minimum spacing between two accepted edges is D+N·W+(N−1)·L+2 cycles.
- edge_cnt and ovr_err update one cycle after the sampled edge.

## Test plan
- **Single pulse.** Reset, arm=1, delay=3, width=2, period=5, burst=1, edge at T:
  - trig_out high at T+4..T+5;
  - done at T+6; busy T+1..T+6;
  - edge_cnt=1.
- **Burst.** delay=0, width=2, period=5, burst=3:
  - rises at T+1, T+6, T+11, each 2 cycles high;
  - done at T+13.
- **Degenerate fields.** width=0, period=0, burst=0:
  - one 1-cycle pulse at T+1+D.
  - Also check width=4, period=3, burst=2: low gap of 1 cycle, rises 5 cycles apart.
- **Overrun.** Second edge during LOW:
  - burst timing unchanged, ovr_err=1, edge_cnt unchanged by the second edge;
  - arm=0 for one cycle clears ovr_err.
- **Abort mid-burst.** arm=0 mid-burst:
  - trig_out=0 and busy=0 next cycle, no done pulse;
  - re-arm and edge restarts cleanly using freshly latched fields.
- **Reset and wrap.**
  - rst_n low during HIGH: trig_out=0 immediately, all outputs at reset values.
  - Preload 2^16−1 accepted edges: one more gives edge_cnt=0.
